// File: rtl/tone_pkg.sv
// Shared types and helpers for the tone frequency detector.
// Holds the FSM state encoding and the timeout constant function.
package tone_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned FREQ_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } tone_det_state_t;

  // Longest period, in clk cycles, still treated as a live tone.
  function automatic int unsigned timeout_cycles(input int unsigned fclk,
                                                 input int unsigned min_freq);
    return (min_freq == 0) ? 32'hFFFF_FFFF : fclk / min_freq;
  endfunction

endpackage

// File: rtl/tone_detector_udiv32.sv
// Serial unsigned restoring divider: one quotient bit per clk, 32 iterations.
// busy covers the iteration cycles; done pulses for one cycle with quo valid.
module udiv32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] num,
  input  logic [31:0] den,
  output logic [31:0] quo,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 5;

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  den_q, den_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W:0]    shifted_c;
  logic [W:0]    trial_c;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    shifted_c = {rem_q, quo_q[W-1]};
    trial_c   = shifted_c - {1'b0, den_q};
    rem_d     = rem_q;
    quo_d     = quo_q;
    den_d     = den_q;
    iter_d    = iter_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (abort) begin
      rem_d  = '0;
      quo_d  = '0;
      den_d  = '0;
      iter_d = '0;
      busy_d = 1'b0;
    end else if (start) begin
      rem_d  = '0;
      quo_d  = num;
      den_d  = den;
      iter_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!trial_c[W]) begin
        rem_d = trial_c[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted_c[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      iter_d = iter_q + IW'(1);
      if (iter_q == IW'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quo  = quo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/tone_detector.sv
// Measures a square-wave frequency in Hz: rising-edge period count in clk
// cycles, then a serial FCLK/period division.
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned FCLK     = 50_000_000,
  parameter int unsigned MIN_FREQ = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tone_in,
  input  logic              enable,
  output logic [FREQ_W-1:0] freq,
  output logic              valid,
  output logic              present,
  output logic              busy
);

  localparam int unsigned       TIMEOUT = timeout_cycles(FCLK, MIN_FREQ);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [FREQ_W-1:0] FCLK_NUM = FREQ_W'(FCLK);

  tone_det_state_t   state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              valid_q, valid_d;
  logic              present_q, present_d;
  logic              rise_c;
  logic              timeout_c;
  logic              div_start_c;
  logic              div_busy;
  logic              div_done;
  logic [FREQ_W-1:0] div_quo;

  // Two-flop synchronizer plus edge register on the asynchronous tone input.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tone_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_c    = s2_q & ~s3_q;
  assign timeout_c = (cnt_q == TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A rise on the timeout cycle keeps the measurement alive.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (rise_c) state_d = MEASURE;
        MEASURE: if (timeout_c && !rise_c) state_d = ARM;
        default: state_d = IDLE;
      endcase
    end
  end

  // Divider is only started when fully idle, including its done cycle.
  always_comb begin
    cnt_d       = cnt_q;
    freq_d      = freq_q;
    valid_d     = 1'b0;
    present_d   = present_q;
    div_start_c = 1'b0;
    if (!enable) begin
      cnt_d     = '0;
      freq_d    = '0;
      present_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: cnt_d = '0;
        ARM: begin
          if (rise_c) cnt_d = CNT_W'(1);
        end
        MEASURE: begin
          if (rise_c) begin
            cnt_d       = CNT_W'(1);
            div_start_c = ~div_busy & ~div_done;
          end else if (timeout_c) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (timeout_c && !rise_c) begin
            freq_d    = '0;
            present_d = 1'b0;
            valid_d   = present_q;
          end else if (div_done) begin
            freq_d    = div_quo;
            valid_d   = 1'b1;
            present_d = 1'b1;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
      present_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      freq_q    <= freq_d;
      valid_q   <= valid_d;
      present_q <= present_d;
    end
  end

  udiv32 u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (div_start_c),
    .abort   (~enable),
    .num     (FCLK_NUM),
    .den     (cnt_q),
    .quo     (div_quo),
    .busy    (div_busy),
    .done    (div_done)
  );

  assign freq    = freq_q;
  assign valid   = valid_q;
  assign present = present_q;
  assign busy    = div_busy;

endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Measures the frequency of an incoming square wave, such as a speaker-drive line or a tone pin, and reports it in Hz as a 32-bit integer.
- Counterpart to the tone generator: the generator turns a Hz value into a toggling output, and this block turns a toggling input back into a Hz value.
- Method: period measurement in clk cycles between consecutive rising edges, followed by a serial division FCLK/period.
- Used for self-test loopback and for tuning/pitch-detection features.

Parameters:
- FCLK, 50_000_000, clock frequency in Hz (must be < 2^32).
- MIN_FREQ, 20, lowest detectable frequency in Hz. TIMEOUT = FCLK/MIN_FREQ clk cycles.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset: synchronous, active-low.
- tone_in  input  1  asynchronous square-wave input.
- enable  input  1  1 = measure; 0 = synchronous clear to idle.
- freq  output  32  last measured frequency in Hz, floor(FCLK/period); 0 when no tone.
- valid  output  1  one-cycle pulse whenever freq is updated.
- present  output  1  1 while a tone is being tracked.
- busy  output  1  divider running.

Behaviour:
- Reset (reset_n=0 at a clk edge) and enable=0 behave identically:
  - state to IDLE, divider aborted, counter cleared;
  - freq=0, valid=0, present=0, busy=0;
  - both take effect on the next edge, even mid-divide; no valid pulse is emitted for the aborted result.
- Input path:
  - 2-FF synchronizer s1, s2, then an edge register s3; rise = s2 & ~s3.
  - Detection latency is 3 clk from a tone_in rising edge (setup met).
  - Minimum detectable period is 2 clk.
- State machine on period counter cnt (32-bit):
  - IDLE: enable=1 -> ARM.
  - ARM: wait for rise. On rise: cnt<=1, go to MEASURE.
  - MEASURE:
    - cnt increments each cycle.
    - On rise: latch period=cnt, cnt<=1. If the divider is idle, start it with divisor=period; if it is busy, discard the period (no error flag).
    - If cnt reaches TIMEOUT with no rise: go to ARM, present<=0, freq<=0, and pulse valid once if present was 1.
- Because TIMEOUT < 2^32, cnt never wraps.
- Divider:
  - Unsigned restoring division, numerator FCLK, divisor period.
  - One quotient bit per cycle, 32 iterations.
  - busy is high from the cycle after start through the final iteration.
- Result timing:
  - If rise is detected at cycle t, freq updates, valid pulses and present<=1 at cycle t+33.
  - freq holds between updates.
- Throughput: one result per 34 clk maximum. Faster tones report every accepted period; intermediate periods are dropped.
- Simultaneous events:
  - A rise on the same cycle as timeout: the rise wins and the timeout is ignored.
  - A divider completion on the same cycle as timeout: the completion is discarded and timeout clears freq to 0.
- Accuracy: the result is truncated (floor). A tonegen-driven input may read up to 1 Hz low, plus period quantization error.

Decomposition:
- Package tone_pkg holds:
  - typedef enum {IDLE, ARM, MEASURE} tone_det_state_t;
  - the constant function timeout_cycles(FCLK, MIN_FREQ).
- Sub-module udiv32 implements the serial restoring divider:
  - inputs: clk, reset_n, start, abort, num[31:0], den[31:0];
  - outputs: quo[31:0], busy, done (1-cycle pulse).
- tone_detector instantiates one udiv32.

Test Plan:
- Basic measurement (FCLK=1_000_000, MIN_FREQ=100, so TIMEOUT=10_000): 1 kHz tone (period 1000 clk), enable=1 -> first valid 33 clk after the second detected rise, freq=1000, present=1; repeats every 1000 clk.
- Frequency change: switch from 1 kHz to 2 kHz (period 500) -> the first result on the first full 500-clk period is freq=2000; no intermediate value other than one mixed period.
- Maximum rate: 333,333 Hz tone (period 3 clk) -> freq=333333; valid pulses no more often than every 34 clk; busy never drops mid-divide.
- Loss of tone: stop toggling after a 1 kHz tone -> exactly 10_000 clk after the last rise, valid pulses once with freq=0 and present=0; state returns to ARM; resuming the tone restores freq=1000.
- Abort: drop enable (and, separately, assert reset_n=0) while busy=1 -> next edge freq=0, present=0, busy=0, and no valid pulse.
- Loopback: tonegen (FCLK=1_000_000, freq=440, onOff=1) driving tone_in -> tone_detector reports 440±1 after the second rising edge, and the value stays stable.
